// File: rtl/rl02_pkg.sv
// Shared types and constants for the RL02 sector sequencer.
package rl02_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned HDR_WORDS = 3;

  // Reflected form of the 0x8005 polynomial; register starts at zero.
  localparam logic [WORD_W-1:0] CRC_POLY = 16'hA001;
  localparam logic [WORD_W-1:0] CRC_INIT = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    HUNT_HDR,
    HDR,
    HUNT_DATA,
    DATA
  } seqState_t;

  // One shift-right CRC step for a single serial bit.
  function automatic logic [WORD_W-1:0] crcStep(input logic [WORD_W-1:0] crc, input logic b);
    logic [WORD_W-1:0] shifted;
    shifted = crc >> 1;
    return (crc[0] ^ b) ? (shifted ^ CRC_POLY) : shifted;
  endfunction

endpackage

// File: rtl/rl02_crc16_serial.sv
// Bit-serial reflected CRC-16 accumulator with synchronous clear.
module rl02_crc16_serial
  import rl02_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              bitIn,
  output logic [WORD_W-1:0] remainder
);

  // Remainder register; clear has priority over an update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      remainder <= CRC_INIT;
    end else if (en) begin
      remainder <= crcStep(remainder, bitIn);
    end
  end

endmodule

// File: rtl/rl02_sector_sequencer.sv
// RL02 sector framing: preamble/sync hunt, fence-post skip, header/data word
// assembly and CRC checking on the decoded real-bit stream.
module rl02_sector_sequencer
  import rl02_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE_ZEROS = 32,
  parameter int unsigned FENCEPOST_ONES     = 8,
  parameter int unsigned DATA_WORDS         = 128,
  parameter int unsigned GAP_TIMEOUT_BITS   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              skip_mfm_bit,
  output logic [WORD_W-1:0] hdr_word,
  output logic              hdr_valid,
  output logic              hdr_crc_ok,
  output logic [WORD_W-1:0] data_word,
  output logic              data_valid,
  output logic              sector_done,
  output logic              sector_crc_ok,
  output logic              sector_err,
  output logic              busy
);

  localparam int unsigned ZERO_W = $clog2(MIN_PREAMBLE_ZEROS + 1);
  localparam int unsigned ONE_W  = $clog2(FENCEPOST_ONES + 1);
  localparam int unsigned WCNT_W = $clog2(DATA_WORDS + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_TIMEOUT_BITS + 1);
  localparam int unsigned BIT_W  = $clog2(WORD_W);

  seqState_t         state, stateN;
  logic [ZERO_W-1:0] zeroRun, zeroRunN;
  logic [ONE_W-1:0]  oneRun, oneRunN;
  logic [WCNT_W-1:0] wordCnt, wordCntN;
  logic [GAP_W-1:0]  gapCnt, gapCntN;
  logic [BIT_W-1:0]  bitCnt, bitCntN;
  logic [WORD_W-1:0] shiftReg, shiftRegN;
  logic [WORD_W-1:0] word0, word0N;
  logic [WORD_W-1:0] crcRem, assembled;
  logic              crcClr, crcEn, isSync, crcMatch, lastBit;

  logic              skipN, hdrValidN, hdrCrcOkN, dataValidN;
  logic              sectorDoneN, sectorCrcOkN, sectorErrN;
  logic [WORD_W-1:0] hdrWordN, dataWordN;

  assign assembled = {bit_in, shiftReg[WORD_W-1:1]};
  assign isSync    = bit_in && (zeroRun >= ZERO_W'(MIN_PREAMBLE_ZEROS));
  assign crcMatch  = (assembled == crcRem);
  assign lastBit   = (bitCnt == BIT_W'(WORD_W - 1));

  rl02_crc16_serial u_crc (
    .clk       (clk),
    .rst       (rst),
    .clr       (crcClr),
    .en        (crcEn),
    .bitIn     (bit_in),
    .remainder (crcRem)
  );

  // Next-state, counter and output computation; abort overrides any bit.
  always_comb begin
    stateN       = state;
    zeroRunN     = zeroRun;
    oneRunN      = oneRun;
    wordCntN     = wordCnt;
    gapCntN      = gapCnt;
    bitCntN      = bitCnt;
    shiftRegN    = shiftReg;
    word0N       = word0;
    crcClr       = 1'b0;
    crcEn        = 1'b0;
    skipN        = 1'b0;
    hdrValidN    = 1'b0;
    dataValidN   = 1'b0;
    sectorDoneN  = 1'b0;
    sectorErrN   = 1'b0;
    hdrWordN     = hdr_word;
    hdrCrcOkN    = hdr_crc_ok;
    dataWordN    = data_word;
    sectorCrcOkN = sector_crc_ok;

    if (!enable) begin
      stateN = IDLE;
    end else if (bit_valid) begin
      unique case (state)
        IDLE: begin
          stateN   = HUNT_HDR;
          zeroRunN = '0;
          oneRunN  = '0;
        end

        HUNT_HDR, HUNT_DATA: begin
          if (!bit_in) begin
            if (zeroRun < ZERO_W'(MIN_PREAMBLE_ZEROS)) zeroRunN = zeroRun + ZERO_W'(1);
            oneRunN = '0;
          end else if (isSync) begin
            stateN   = (state == HUNT_HDR) ? HDR : DATA;
            bitCntN  = '0;
            wordCntN = '0;
            zeroRunN = '0;
            oneRunN  = '0;
            crcClr   = 1'b1;
          end else begin
            zeroRunN = '0;
            if (oneRun == ONE_W'(FENCEPOST_ONES - 1)) begin
              oneRunN = '0;
              skipN   = 1'b1;
            end else begin
              oneRunN = oneRun + ONE_W'(1);
            end
          end
          // Header-to-data gap watchdog; a sync on the final bit still wins.
          if (state == HUNT_DATA && !isSync) begin
            if (gapCnt == GAP_W'(GAP_TIMEOUT_BITS - 1)) begin
              sectorErrN = 1'b1;
              stateN     = HUNT_HDR;
              zeroRunN   = '0;
              oneRunN    = '0;
              gapCntN    = '0;
            end else begin
              gapCntN = gapCnt + GAP_W'(1);
            end
          end
        end

        HDR: begin
          shiftRegN = assembled;
          bitCntN   = bitCnt + BIT_W'(1);
          crcEn     = (wordCnt < WCNT_W'(HDR_WORDS - 1));
          if (lastBit) begin
            wordCntN = wordCnt + WCNT_W'(1);
            if (wordCnt == '0) begin
              word0N = assembled;
            end else if (wordCnt == WCNT_W'(HDR_WORDS - 1)) begin
              hdrValidN = 1'b1;
              hdrWordN  = word0;
              hdrCrcOkN = crcMatch;
              zeroRunN  = '0;
              oneRunN   = '0;
              gapCntN   = '0;
              if (crcMatch) begin
                stateN = HUNT_DATA;
              end else begin
                sectorErrN = 1'b1;
                stateN     = HUNT_HDR;
              end
            end
          end
        end

        DATA: begin
          shiftRegN = assembled;
          bitCntN   = bitCnt + BIT_W'(1);
          crcEn     = (wordCnt < WCNT_W'(DATA_WORDS));
          if (lastBit) begin
            wordCntN = wordCnt + WCNT_W'(1);
            if (wordCnt < WCNT_W'(DATA_WORDS)) begin
              dataValidN = 1'b1;
              dataWordN  = assembled;
            end else begin
              sectorDoneN  = 1'b1;
              sectorCrcOkN = crcMatch;
              stateN       = HUNT_HDR;
              zeroRunN     = '0;
              oneRunN      = '0;
            end
          end
        end

        default: stateN = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      zeroRun       <= '0;
      oneRun        <= '0;
      wordCnt       <= '0;
      gapCnt        <= '0;
      bitCnt        <= '0;
      shiftReg      <= '0;
      word0         <= '0;
      skip_mfm_bit  <= 1'b0;
      hdr_word      <= '0;
      hdr_valid     <= 1'b0;
      hdr_crc_ok    <= 1'b0;
      data_word     <= '0;
      data_valid    <= 1'b0;
      sector_done   <= 1'b0;
      sector_crc_ok <= 1'b0;
      sector_err    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= stateN;
      zeroRun       <= zeroRunN;
      oneRun        <= oneRunN;
      wordCnt       <= wordCntN;
      gapCnt        <= gapCntN;
      bitCnt        <= bitCntN;
      shiftReg      <= shiftRegN;
      word0         <= word0N;
      skip_mfm_bit  <= skipN;
      hdr_word      <= hdrWordN;
      hdr_valid     <= hdrValidN;
      hdr_crc_ok    <= hdrCrcOkN;
      data_word     <= dataWordN;
      data_valid    <= dataValidN;
      sector_done   <= sectorDoneN;
      sector_crc_ok <= sectorCrcOkN;
      sector_err    <= sectorErrN;
      busy          <= (stateN != IDLE);
    end
  end

endmodule

// File: tb/tb_rl02_sector_sequencer.sv
// Self-checking bench for rl02_sector_sequencer: scenario tasks with inline checks.
module tb_rl02_sector_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        skip_mfm_bit, hdr_valid, hdr_crc_ok, data_valid;
  logic        sector_done, sector_crc_ok, sector_err, busy;
  logic [15:0] hdr_word, data_word;

  int total = 0;
  int bad = 0;
  int bitsSent = 0;

  int          skipAt[$];
  int          hdrAt[$];
  int          errAt[$];
  int          doneAt[$];
  logic [15:0] hdrWordQ[$];
  logic        hdrOkQ[$];
  logic [15:0] dataQ[$];
  logic        doneOkQ[$];
  logic [15:0] dataWords[128];

  always #5 clk = ~clk;

  rl02_sector_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .skip_mfm_bit  (skip_mfm_bit),
    .hdr_word      (hdr_word),
    .hdr_valid     (hdr_valid),
    .hdr_crc_ok    (hdr_crc_ok),
    .data_word     (data_word),
    .data_valid    (data_valid),
    .sector_done   (sector_done),
    .sector_crc_ok (sector_crc_ok),
    .sector_err    (sector_err),
    .busy          (busy)
  );

  // Strobe monitor, tagging each event with the index of the last bit sent.
  always @(negedge clk) begin
    if (!rst) begin
      if (skip_mfm_bit) skipAt.push_back(bitsSent);
      if (hdr_valid) begin
        hdrAt.push_back(bitsSent);
        hdrWordQ.push_back(hdr_word);
        hdrOkQ.push_back(hdr_crc_ok);
      end
      if (sector_err) errAt.push_back(bitsSent);
      if (data_valid) dataQ.push_back(data_word);
      if (sector_done) begin
        doneAt.push_back(bitsSent);
        doneOkQ.push_back(sector_crc_ok);
      end
    end
  end

  // Reference CRC: reflected 0x8005, zero init, words fed LSB first.
  function automatic logic [15:0] refCrc(input logic [15:0] words[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (words[k]) begin
      for (int i = 0; i < 16; i++) begin
        if (c[0] ^ words[k][i]) c = (c >> 1) ^ 16'hA001;
        else c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic sendBit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    bitsSent++;
    #1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sendZeros(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b0);
  endtask

  task automatic sendWord(input logic [15:0] w);
    for (int i = 0; i < 16; i++) sendBit(w[i]);
  endtask

  task automatic sendHeaderN(input int nz, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] flip);
    logic [15:0] q[$];
    q.push_back(w0);
    q.push_back(w1);
    sendZeros(nz);
    sendBit(1'b1);
    sendWord(w0);
    sendWord(w1);
    sendWord(refCrc(q) ^ flip);
  endtask

  task automatic sendHeader(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] flip);
    sendHeaderN(33 + int'($urandom_range(0, 15)), w0, w1, flip);
  endtask

  task automatic sendSector(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] flip);
    logic [15:0] q[$];
    sendHeader(w0, w1, 16'h0000);
    sendZeros(33 + int'($urandom_range(0, 15)));
    sendBit(1'b1);
    for (int k = 0; k < 128; k++) begin
      q.push_back(dataWords[k]);
      sendWord(dataWords[k]);
    end
    sendWord(refCrc(q) ^ flip);
  endtask

  task automatic clearLogs();
    skipAt.delete(); hdrAt.delete(); errAt.delete(); doneAt.delete();
    hdrWordQ.delete(); hdrOkQ.delete(); dataQ.delete(); doneOkQ.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    enable = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearLogs();
    bitsSent = 0;
  endtask

  task automatic test_reset();
    doReset();
    total++; if ({skip_mfm_bit, hdr_valid, hdr_crc_ok, data_valid, sector_done, sector_crc_ok, sector_err} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {skip_mfm_bit, hdr_valid, hdr_crc_ok, data_valid, sector_done, sector_crc_ok, sector_err});
    end
    total++; if ({hdr_word, data_word} !== 32'h0) begin
      bad++; $display("FAIL reset_words got=%h exp=0", {hdr_word, data_word});
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_header_good();
    logic [15:0] w0, w1;
    for (int it = 0; it < 4; it++) begin
      doReset();
      enable = 1'b1;
      w0 = (it == 0) ? 16'h0A53 : 16'($urandom);
      w1 = (it == 0) ? 16'h0000 : 16'($urandom);
      sendHeaderN(40, w0, w1, 16'h0000);
      total++; if (hdrAt.size() !== 1) begin bad++; $display("FAIL hdr_count got=%0d exp=1", hdrAt.size()); end
      if (hdrAt.size() == 1) begin
        total++; if (hdrAt[0] !== bitsSent) begin bad++; $display("FAIL hdr_timing got=%0d exp=%0d", hdrAt[0], bitsSent); end
        total++; if (hdrWordQ[0] !== w0) begin bad++; $display("FAIL hdr_word got=%h exp=%h", hdrWordQ[0], w0); end
        total++; if (hdrOkQ[0] !== 1'b1) begin bad++; $display("FAIL hdr_crc_ok got=%b exp=1", hdrOkQ[0]); end
      end
      total++; if (hdr_word !== w0) begin bad++; $display("FAIL hdr_word_held got=%h exp=%h", hdr_word, w0); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hdr_busy got=%b exp=1", busy); end
      total++; if (errAt.size() !== 0) begin bad++; $display("FAIL hdr_no_err got=%0d exp=0", errAt.size()); end
      // Now hunting data: a sync plus one word must give a data strobe.
      w1 = 16'($urandom);
      sendZeros(34);
      sendBit(1'b1);
      sendWord(w1);
      total++; if (dataQ.size() !== 1 || dataQ[0] !== w1) begin
        bad++; $display("FAIL hunt_data_word got=%0d/%h exp=1/%h", dataQ.size(), (dataQ.size() > 0) ? dataQ[0] : 16'hxxxx, w1);
      end
    end
  endtask

  task automatic test_header_bad();
    logic [15:0] w0, w0b, w1b;
    doReset();
    enable = 1'b1;
    w0  = 16'($urandom);
    w0b = 16'($urandom);
    w1b = 16'($urandom);
    sendHeader(w0, 16'h0000, 16'h0008);
    total++; if (hdrAt.size() !== 1 || hdrOkQ[0] !== 1'b0) begin
      bad++; $display("FAIL badhdr_crc_ok got=%0d strobes exp=1 with ok=0", hdrAt.size());
    end
    total++; if (errAt.size() !== 1 || errAt[0] !== bitsSent) begin
      bad++; $display("FAIL badhdr_err got=%0d strobes exp=1 at bit %0d", errAt.size(), bitsSent);
    end
    sendHeader(w0b, w1b, 16'h0000);
    total++; if (hdrAt.size() !== 2 || hdrOkQ[1] !== 1'b1 || hdrWordQ[1] !== w0b) begin
      bad++; $display("FAIL badhdr_recover got=%0d strobes hdr_word=%h exp=2 ok=1 %h", hdrAt.size(), hdr_word, w0b);
    end
    total++; if (errAt.size() !== 1) begin bad++; $display("FAIL badhdr_err_count got=%0d exp=1", errAt.size()); end
  endtask

  task automatic test_fencepost();
    int mark, len;
    int expQ[$];
    doReset();
    enable = 1'b1;
    sendBit(1'b0);
    sendBit(1'b0);
    mark = bitsSent;
    for (int j = 0; j < 8; j++) sendBit(1'b1);
    total++; if (skipAt.size() !== 1 || skipAt[0] !== mark + 8) begin
      bad++; $display("FAIL skip_8 got=%0d pulses exp=1 at bit %0d", skipAt.size(), mark + 8);
    end
    sendBit(1'b0);
    mark = bitsSent;
    for (int j = 0; j < 16; j++) sendBit(1'b1);
    total++; if (skipAt.size() !== 3 || skipAt[1] !== mark + 8 || skipAt[2] !== mark + 16) begin
      bad++; $display("FAIL skip_16 got=%0d pulses exp=3 at bits %0d,%0d", skipAt.size(), mark + 8, mark + 16);
    end
    // Random one-runs: a pulse on every 8th consecutive one.
    skipAt.delete();
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 20));
      sendBit(1'b0);
      mark = bitsSent;
      for (int j = 1; j <= len; j++) begin
        sendBit(1'b1);
        if (j % 8 == 0) expQ.push_back(mark + j);
      end
    end
    total++; if (skipAt.size() !== expQ.size()) begin
      bad++; $display("FAIL skip_random_count got=%0d exp=%0d", skipAt.size(), expQ.size());
    end else begin
      foreach (expQ[i]) begin
        total++; if (skipAt[i] !== expQ[i]) begin bad++; $display("FAIL skip_random_at got=%0d exp=%0d", skipAt[i], expQ[i]); end
      end
    end
    total++; if (hdrAt.size() !== 0) begin bad++; $display("FAIL skip_no_sync got=%0d exp=0", hdrAt.size()); end
  endtask

  task automatic test_preamble();
    logic [15:0] w0, w1;
    doReset();
    enable = 1'b1;
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    sendBit(1'b1);
    sendZeros(31);
    sendBit(1'b1);
    sendHeaderN(32, w0, w1, 16'h0000);
    total++; if (hdrAt.size() !== 1 || hdrWordQ[0] !== w0 || hdrOkQ[0] !== 1'b1) begin
      bad++; $display("FAIL preamble_boundary got=%0d strobes hdr_word=%h exp=1 %h", hdrAt.size(), hdr_word, w0);
    end
    total++; if (errAt.size() !== 0) begin bad++; $display("FAIL preamble_no_err got=%0d exp=0", errAt.size()); end
  endtask

  task automatic test_full_sector();
    logic [15:0] flip;
    doReset();
    enable = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 128; k++) dataWords[k] = (s == 0) ? 16'(k) : 16'($urandom);
      flip = (s == 0) ? 16'h0000 : (16'h0001 << $urandom_range(0, 15));
      clearLogs();
      sendSector(16'($urandom), 16'($urandom), flip);
      total++; if (dataQ.size() !== 128) begin bad++; $display("FAIL sector_data_count got=%0d exp=128", dataQ.size()); end
      if (dataQ.size() == 128) begin
        for (int k = 0; k < 128; k++) begin
          total++; if (dataQ[k] !== dataWords[k]) begin bad++; $display("FAIL sector_data_%0d got=%h exp=%h", k, dataQ[k], dataWords[k]); end
        end
      end
      total++; if (doneAt.size() !== 1 || doneAt[0] !== bitsSent) begin
        bad++; $display("FAIL sector_done got=%0d strobes exp=1 at bit %0d", doneAt.size(), bitsSent);
      end
      total++; if (doneOkQ.size() !== 1 || doneOkQ[0] !== (s == 0)) begin
        bad++; $display("FAIL sector_crc_ok got=%0d strobes exp ok=%0d", doneOkQ.size(), (s == 0));
      end
      total++; if (sector_crc_ok !== (s == 0)) begin bad++; $display("FAIL sector_crc_ok_held got=%b exp=%0d", sector_crc_ok, (s == 0)); end
      total++; if (errAt.size() !== 0) begin bad++; $display("FAIL sector_no_err got=%0d exp=0", errAt.size()); end
    end
  endtask

  task automatic test_gap_timeout();
    int mark, run;
    logic b;
    logic [15:0] w;
    doReset();
    enable = 1'b1;
    sendHeader(16'($urandom), 16'($urandom), 16'h0000);
    mark = bitsSent;
    run = 0;
    for (int i = 1; i <= 1024; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run >= 10) b = 1'b1;
      run = b ? 0 : run + 1;
      sendBit(b);
      if (i == 1023) begin
        total++; if (errAt.size() !== 0) begin bad++; $display("FAIL gap_early got=%0d exp=0", errAt.size()); end
      end
    end
    total++; if (errAt.size() !== 1 || errAt[0] !== mark + 1024) begin
      bad++; $display("FAIL gap_timeout got=%0d strobes exp=1 at bit %0d", errAt.size(), mark + 1024);
    end
    w = 16'($urandom);
    sendHeader(w, 16'($urandom), 16'h0000);
    total++; if (hdrAt.size() !== 2 || hdrWordQ[1] !== w || hdrOkQ[1] !== 1'b1) begin
      bad++; $display("FAIL gap_rehunt got=%0d strobes exp=2 word %h", hdrAt.size(), w);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w0, dw;
    doReset();
    enable = 1'b1;
    w0 = 16'($urandom) | 16'h0001;
    sendHeader(w0, 16'($urandom), 16'h0000);
    sendZeros(36);
    sendBit(1'b1);
    for (int k = 0; k < 5; k++) sendWord(16'($urandom));
    dw = 16'($urandom);
    for (int i = 0; i < 15; i++) sendBit(dw[i]);
    bit_in    = dw[15];
    bit_valid = 1'b1;
    enable    = 1'b0;
    @(posedge clk);
    bitsSent++;
    #1;
    bit_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL abort_strobe got=%b exp=0", data_valid); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) sendBit(1'($urandom_range(0, 1)));
    total++; if (dataQ.size() !== 5 || doneAt.size() !== 0 || hdrAt.size() !== 1) begin
      bad++; $display("FAIL abort_no_strobes got data=%0d done=%0d hdr=%0d exp=5/0/1", dataQ.size(), doneAt.size(), hdrAt.size());
    end
    total++; if (hdr_word !== w0) begin bad++; $display("FAIL abort_hdr_held got=%h exp=%h", hdr_word, w0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_hdr();
    doReset();
    enable = 1'b1;
    for (int k = 0; k < 128; k++) dataWords[k] = 16'($urandom);
    sendSector(16'($urandom) | 16'h0100, 16'($urandom), 16'h0000);
    total++; if (sector_crc_ok !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ok got=%b exp=1", sector_crc_ok); end
    sendZeros(34);
    sendBit(1'b1);
    for (int i = 0; i < 10; i++) sendBit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({hdr_word, data_word, hdr_valid, hdr_crc_ok, data_valid, sector_done, sector_crc_ok, sector_err, skip_mfm_bit, busy} !== 40'h0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {hdr_word, data_word, hdr_valid, hdr_crc_ok, data_valid, sector_done, sector_crc_ok, sector_err, skip_mfm_bit, busy});
    end
    rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_header_good();
    test_header_bad();
    test_fencepost();
    test_preamble();
    test_full_sector();
    test_gap_timeout();
    test_abort();
    test_reset_mid_hdr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
